// File: rtl/program_loader.sv
// Byte-stream program loader: writes two 4-bit opcodes per data byte into instruction RAM
// and holds the CPU in reset while loading. Define PROGRAM_LOADER_CHECKSUM_EN for the trailing XOR checksum.
module program_loader #(
  parameter int ADDR_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [OPCODE_WIDTH-1:0] mem_wdata,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned MAX_LEN = 1 << (ADDR_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WR_HI,
    WR_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t                state, next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [7:0]            cnt;
  logic [7:0]            byte_q;
  logic                  xfer;
  logic                  len_bad;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign xfer    = rx_valid && rx_ready;
  assign len_bad = (rx_data == 8'd0) || (32'(rx_data) > MAX_LEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  // done/error/cpu_hold decode straight from state, so reset clears them in the same cycle
  always_comb begin
    next      = state;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next = LEN;
      end
      LEN: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) next = len_bad ? ERR : DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) next = WR_HI;
      end
      WR_HI: begin
        cpu_hold  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = OPCODE_WIDTH'(byte_q[7:4]);
        next      = WR_LO;
      end
      WR_LO: begin
        cpu_hold  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr + ADDR_WIDTH'(1);
        mem_wdata = OPCODE_WIDTH'(byte_q[3:0]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        next      = (cnt != 8'd0) ? DATA : CHK;
`else
        next      = (cnt != 8'd0) ? DATA : DONE;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) next = (rx_data == csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) next = LEN;
      end
      ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) next = LEN;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      cnt    <= '0;
      byte_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            ptr  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) cnt <= rx_data;
        end
        DATA: begin
          if (xfer) begin
            byte_q <= rx_data;
            cnt    <= cnt - 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum   <= csum ^ rx_data;
`endif
          end
        end
        WR_LO: begin
          ptr <= ptr + ADDR_WIDTH'(2);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a queue-based image model.
module tb_program_loader;

  localparam int AW      = 8;
  localparam int MAX_LEN = 128;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  int unsigned elapsed = 0;
  wr_t         got[$];
  u8           img[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_loader #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture every write; the loader must never accept a byte while writing.
  always @(negedge clk) begin
    if (mem_we) begin
      got.push_back(wr_t'{addr: mem_addr, data: mem_wdata});
      check("rdy_during_wr", 32'(rx_ready), 32'd0);
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic send_bytes(input u8 q[$], input int gap_pct, input int start_at);
    int idx = 0;
    int iter = 0;
    bit pulsed = 1'b0;
    bit xfer;
    while (idx < q.size() && iter < 4000) begin
      start    = 1'b0;
      rx_valid = (int'($urandom_range(99)) >= gap_pct);
      rx_data  = rx_valid ? q[idx] : u8'($urandom);
      if (idx == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      xfer = rx_valid && rx_ready;
      @(negedge clk);
      if (xfer) idx++;
      iter++;
    end
    start    = 1'b0;
    rx_valid = 1'b0;
    check("send_budget", 32'(idx), 32'(q.size()));
  endtask

  task automatic run_load(input u8 im[$], input int gap_pct, input int start_at, input string name);
    u8   n = im[0];
    u8   b;
    u8   x = 8'd0;
    wr_t exp_q[$];
    u8   q[$];
    bit  exp_done;
    int  consumed;
    int  w = 0;
    if (n == 8'd0 || int'(n) > MAX_LEN) begin
      exp_done = 1'b0;
      consumed = 1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        b = im[1 + i];
        exp_q.push_back(wr_t'{addr: AW'(2 * i),     data: b[7:4]});
        exp_q.push_back(wr_t'{addr: AW'(2 * i + 1), data: b[3:0]});
        x = x ^ b;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      consumed = int'(n) + 2;
      exp_done = (im[int'(n) + 1] == x);
`else
      consumed = int'(n) + 1;
      exp_done = 1'b1;
`endif
    end
    for (int i = 0; i < consumed; i++) q.push_back(im[i]);
    got.delete();
    do_start();
    send_bytes(q, gap_pct, start_at);
    while (!(done || error) && w < 50) begin
      @(negedge clk);
      w++;
    end
    elapsed = cyc - c0;
    check({name, "_finish_in_time"}, 32'(w < 50), 32'd1);
    check({name, "_done"},     32'(done),     32'(exp_done));
    check({name, "_error"},    32'(error),    32'(!exp_done));
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({name, "_nwrites"},  32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check({name, "_wr_addr"}, 32'(got[i].addr), 32'(exp_q[i].addr));
      check({name, "_wr_data"}, 32'(got[i].data), 32'(exp_q[i].data));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    u8  x;
    u8  b;
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready",  32'(rx_ready),  32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),  32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    reset = 1'b1;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img = '{8'h02, 8'h12, 8'h34, 8'h26};
    run_load(img, 0, -1, "basic");
    check("basic_latency", elapsed, 32'd8);
    img = '{8'h02, 8'h12, 8'h34, 8'h27};
    run_load(img, 0, -1, "bad_csum");
`else
    img = '{8'h02, 8'h12, 8'h34};
    run_load(img, 0, -1, "basic");
    check("basic_latency", elapsed, 32'd7);
    img = '{8'h01, 8'hAB};
    run_load(img, 0, -1, "nocsum");
    check("nocsum_latency", elapsed, 32'd4);
`endif

    img = '{8'h00};
    run_load(img, 0, -1, "len0");
    img = '{8'h81};
    run_load(img, 0, -1, "len81");

    img.delete();
    img.push_back(8'h80);
    x = 8'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      b = u8'($urandom);
      img.push_back(b);
      x = x ^ b;
    end
    img.push_back(x);
    run_load(img, 0, -1, "len80");
    check("len80_last_addr", 32'(got.size() > 0 ? got[got.size() - 1].addr : 8'd0), 32'hFF);

    for (int t = 0; t < 20; t++) begin
      img.delete();
      if ($urandom_range(9) == 0) begin
        n = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(255, 129));
        img.push_back(u8'(n));
      end else begin
        n = int'($urandom_range(16, 1));
        img.push_back(u8'(n));
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
          b = u8'($urandom);
          img.push_back(b);
          x = x ^ b;
        end
        img.push_back(($urandom_range(3) == 0) ? (x ^ u8'($urandom_range(255, 1))) : x);
      end
      run_load(img, 40, -1, "rand");
    end

    img.delete();
    img.push_back(8'd4);
    x = 8'd0;
    for (int i = 0; i < 4; i++) begin
      b = u8'($urandom);
      img.push_back(b);
      x = x ^ b;
    end
    img.push_back(x);
    run_load(img, 0, 1, "busy_start");

    got.delete();
    do_start();
    img = '{8'h03, 8'h5A};
    send_bytes(img, 0, -1);
    @(negedge clk);
    check("wrlo_we",   32'(mem_we),   32'd1);
    check("wrlo_addr", 32'(mem_addr), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midrst_outputs",
          32'({rx_ready, mem_we, cpu_hold, done, error, mem_wdata, mem_addr}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    img.delete();
    img.push_back(8'd3);
    x = 8'd0;
    for (int i = 0; i < 3; i++) begin
      b = u8'($urandom);
      img.push_back(b);
      x = x ^ b;
    end
    img.push_back(x);
    run_load(img, 0, -1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory interface: receives a program image as a byte stream and writes 4-bit opcodes into the instruction memory that the CPU fetches from.
- Holds the CPU in reset while loading.
- Sits between a byte source (UART receiver or test bench) and the write port of the instruction RAM, in place of the fixed ROM.
- Image format: length byte N, then N data bytes (two opcodes per byte, high nibble first), then a checksum byte.

Parameters:
ADDR_WIDTH, 8, instruction memory address width; capacity 2^ADDR_WIDTH opcodes
OPCODE_WIDTH, 4, opcode width; fixed at 4 (two opcodes per byte)

Ports:
clk  input  1  system clock (divided CPU clock)
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse: begin a new load
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  OPCODE_WIDTH  opcode to write
cpu_hold  output  1  high = hold CPU (PC/ACC) in reset
done  output  1  load completed successfully; sticky
error  output  1  load failed; sticky

Behaviour:
- Async active-low reset → state IDLE; all outputs 0; ptr=0; cnt=0; csum=0.
- Byte transfer occurs on a cycle where rx_valid && rx_ready. rx_data is sampled only then. rx_valid may be held high indefinitely.
- States:
  - IDLE:
    - rx_ready=0.
    - start → LEN; clear ptr, csum, done, error; set cpu_hold=1.
  - LEN:
    - rx_ready=1.
    - On transfer: cnt=rx_data.
    - rx_data==0 or rx_data > 2^(ADDR_WIDTH-1) → ERR; else → DATA.
  - DATA:
    - rx_ready=1.
    - On transfer: latch byte; csum ^= byte; cnt-=1; → WR_HI.
  - WR_HI:
    - rx_ready=0.
    - mem_we=1, mem_addr=ptr, mem_wdata=byte[7:4].
    - → WR_LO.
  - WR_LO:
    - rx_ready=0.
    - mem_we=1, mem_addr=ptr+1, mem_wdata=byte[3:0].
    - ptr+=2.
    - → DATA if cnt!=0, else → CHK.
  - CHK:
    - rx_ready=1.
    - On transfer: rx_data==csum → DONE, else → ERR.
  - DONE:
    - done=1, cpu_hold=0.
    - start → LEN (new load).
  - ERR:
    - error=1, cpu_hold stays 1 (memory contents invalid).
    - start → LEN.
- mem_we is high only in WR_HI/WR_LO, exactly 2 cycles per data byte.
- Minimum load time for N bytes: 1 + 3N + 1 cycles after start, with rx_valid held high.
- Address arithmetic is modulo 2^ADDR_WIDTH. The length check guarantees no wrap: the last write is at 2N-1 ≤ 2^ADDR_WIDTH-1.
- Memory beyond 2N-1 is not written.
- start while in LEN/DATA/WR_HI/WR_LO/CHK is ignored; the current load continues.
- start and rx_valid in the same cycle in IDLE: only start is acted on; rx_ready is 0, so no byte is consumed.
- Reset mid-load: immediate return to IDLE with cpu_hold=0. Memory contents are partial and undefined; software must reload.
- done and error are never both 1.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN
- Defined: CHK state present; trailing checksum byte = XOR of all N data bytes; mismatch → ERR.
- Undefined:
  - No CHK state and no csum register.
  - WR_LO with cnt==0 → DONE directly.
  - Image is length byte plus N data bytes only.
  - error is asserted only for an invalid length.

Test Plan:
- Checksum enabled, basic load: start; send 0x02, 0x12, 0x34, 0x26 (0x12^0x34=0x26) → writes addr0=1, 1=2, 2=3, 3=4, in that order. Then done=1, cpu_hold=0, error=0.
- Bad checksum: same as above but checksum byte 0x27 → error=1, done=0, cpu_hold=1. The four writes still occurred.
- Invalid length: rx_data 0x00 and separately 0x81 (ADDR_WIDTH=8) → ERR right after the length byte, no mem_we pulses. Length 0x80 is accepted: 256 writes, last at addr 0xFF.
- Backpressure/gaps: random rx_valid gaps; rx_ready observed 0 in WR_HI/WR_LO. No byte lost or duplicated, and write order is unchanged.
- Start ignored while busy; reset mid-load: pulse start during DATA → no effect. Drop reset low during WR_LO → all outputs 0 within the same cycle; next start performs a clean full load.
- Macro undefined: send 0x01, 0xAB → writes addr0=0xA, addr1=0xB; done=1 right after WR_LO; no checksum byte consumed.
